// File: rtl/nios2_debug_pkg.sv
// Shared constants for the Nios II JTAG debug command path.
// Command kinds and default widths used by the sync block, its FIFO and its interface.
package nios2_debug_pkg;

   localparam logic CMD_DR = 1'b0;
   localparam logic CMD_IR = 1'b1;

   localparam int DBG_DATA_W = 38;
   localparam int DBG_IR_W   = 2;

   // Packed FIFO entry layout: {kind, ir, data}
   function automatic int entry_width(input int data_w, input int ir_w);
      return 1 + ir_w + data_w;
   endfunction

endpackage

// File: rtl/nios2_debug_cmd_sync_if.sv
// Command handshake between the debug sync block (master) and the CPU debug logic (slave).
interface nios2_debug_cmd_sync_if #(
   parameter int DATA_W = nios2_debug_pkg::DBG_DATA_W,
   parameter int IR_W   = nios2_debug_pkg::DBG_IR_W
);

   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_kind;
   logic [IR_W-1:0]   cmd_ir;
   logic [DATA_W-1:0] cmd_data;
   logic              cmd_take_action;

   modport master (
      output cmd_valid, cmd_kind, cmd_ir, cmd_data, cmd_take_action,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_kind, cmd_ir, cmd_data, cmd_take_action,
      output cmd_ready
   );

endinterface

// File: rtl/nios2_debug_cmd_fifo.sv
// First-word-fall-through FIFO; head is read straight from storage so a pushed entry
// appears on the outputs the cycle after the push edge.
module nios2_debug_cmd_fifo #(
   parameter int WIDTH = 41,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_reg;
   logic [AW:0]      rd_ptr_reg;
   logic             do_push;
   logic             do_pop;

   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign level = wr_ptr_reg - rd_ptr_reg;
   assign head  = mem[rd_ptr_reg[AW-1:0]];

   // A pop frees the head slot in the same cycle, so a full FIFO still accepts a push then
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/nios2_debug_cmd_sync.sv
// System-clock side of the JTAG debug slave: resynchronises update-DR/IR strobes from TCK,
// turns rising edges into commands and queues them for the CPU debug logic.
module nios2_debug_cmd_sync
   import nios2_debug_pkg::*;
#(
   parameter int DATA_W      = DBG_DATA_W,
   parameter int IR_W        = DBG_IR_W,
   parameter int SYNC_STAGES = 2,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            vs_udr,
   input  logic                            vs_uir,
   input  logic [IR_W-1:0]                 ir_in,
   input  logic [DATA_W-1:0]               sr,
   nios2_debug_cmd_sync_if.master          cmd,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
   output logic                            overflow,
   input  logic                            overflow_clr
);

   localparam int ENTRY_W = entry_width(DATA_W, IR_W);
   localparam int HOLD_W  = $clog2(SYNC_STAGES + 2);
   localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(SYNC_STAGES + 1);

   logic [SYNC_STAGES-1:0] udr_sync_reg, uir_sync_reg;
   logic                   udr_prev_reg, uir_prev_reg;
   logic [HOLD_W-1:0]      hold_cnt_reg;
   logic                   pend_valid_reg, pend_valid_next;
   logic [ENTRY_W-1:0]     pend_entry_reg, pend_entry_next;
   logic                   overflow_reg, overflow_next;

   logic                   holdoff, dr_ev, ir_ev, lost;
   logic [ENTRY_W-1:0]     dr_entry, ir_entry, push_entry, head;
   logic                   push, pop, full, empty;

   assign holdoff  = (hold_cnt_reg != '0);
   assign dr_ev    = udr_sync_reg[SYNC_STAGES-1] & ~udr_prev_reg & ~holdoff;
   assign ir_ev    = uir_sync_reg[SYNC_STAGES-1] & ~uir_prev_reg & ~holdoff;
   assign dr_entry = {CMD_DR, ir_in, sr};
   assign ir_entry = {CMD_IR, ir_in, {DATA_W{1'b0}}};

   // prev keeps tracking during hold-off so a strobe high at reset release never fires
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         udr_sync_reg   <= '0;
         uir_sync_reg   <= '0;
         udr_prev_reg   <= 1'b0;
         uir_prev_reg   <= 1'b0;
         hold_cnt_reg   <= HOLD_INIT;
         pend_valid_reg <= 1'b0;
         pend_entry_reg <= '0;
         overflow_reg   <= 1'b0;
      end else begin
         udr_sync_reg   <= {udr_sync_reg[SYNC_STAGES-2:0], vs_udr};
         uir_sync_reg   <= {uir_sync_reg[SYNC_STAGES-2:0], vs_uir};
         udr_prev_reg   <= udr_sync_reg[SYNC_STAGES-1];
         uir_prev_reg   <= uir_sync_reg[SYNC_STAGES-1];
         if (holdoff) hold_cnt_reg <= hold_cnt_reg - 1'b1;
         pend_valid_reg <= pend_valid_next;
         pend_entry_reg <= pend_entry_next;
         overflow_reg   <= overflow_next;
      end
   end

   // One FIFO push per cycle: pending DR first, then IR, then DR
   always_comb begin
      push            = 1'b0;
      push_entry      = '0;
      pend_valid_next = pend_valid_reg;
      pend_entry_next = pend_entry_reg;
      lost            = 1'b0;
      if (pend_valid_reg) begin
         push            = 1'b1;
         push_entry      = pend_entry_reg;
         pend_valid_next = dr_ev | ir_ev;
         pend_entry_next = dr_ev ? dr_entry : ir_entry;
         lost            = dr_ev & ir_ev;
      end else if (ir_ev) begin
         push            = 1'b1;
         push_entry      = ir_entry;
         pend_valid_next = dr_ev;
         pend_entry_next = dr_entry;
      end else if (dr_ev) begin
         push            = 1'b1;
         push_entry      = dr_entry;
      end
   end

   assign pop = ~empty & cmd.cmd_ready;

   always_comb begin
      overflow_next = overflow_reg & ~overflow_clr;
      if ((push & full & ~pop) | lost) overflow_next = 1'b1;
   end

   nios2_debug_cmd_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .level     (fifo_level)
   );

   assign cmd.cmd_valid       = ~empty;
   assign cmd.cmd_kind        = empty ? 1'b0 : head[ENTRY_W-1];
   assign cmd.cmd_ir          = empty ? '0 : head[DATA_W +: IR_W];
   assign cmd.cmd_data        = empty ? '0 : head[DATA_W-1:0];
   assign cmd.cmd_take_action = ~empty & (head[ENTRY_W-1] == CMD_DR) & head[DATA_W-1];
   assign overflow            = overflow_reg;

endmodule

// File: tb/tb_nios2_debug_cmd_sync.sv
// Directed self-checking bench for nios2_debug_cmd_sync with default parameters.
module tb_nios2_debug_cmd_sync;
   import nios2_debug_pkg::*;

   localparam int DATA_W = 38;
   localparam int IR_W   = 2;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              vs_udr = 1'b0;
   logic              vs_uir = 1'b0;
   logic [IR_W-1:0]   ir_in = '0;
   logic [DATA_W-1:0] sr = '0;
   logic [2:0]        fifo_level;
   logic              overflow;
   logic              overflow_clr = 1'b0;

   int checks = 0;
   int failures = 0;

   nios2_debug_cmd_sync_if #(.DATA_W(DATA_W), .IR_W(IR_W)) cmd_bus ();

   nios2_debug_cmd_sync #(
      .DATA_W(DATA_W), .IR_W(IR_W), .SYNC_STAGES(2), .FIFO_DEPTH(4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .vs_udr       (vs_udr),
      .vs_uir       (vs_uir),
      .ir_in        (ir_in),
      .sr           (sr),
      .cmd          (cmd_bus),
      .fifo_level   (fifo_level),
      .overflow     (overflow),
      .overflow_clr (overflow_clr)
   );

   always #5 clk = ~clk;

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Strobe high 3 cycles, low 3 cycles; push happens on the third edge
   task automatic dr_event(input logic [DATA_W-1:0] d, input logic [IR_W-1:0] ir);
      sr = d;
      ir_in = ir;
      vs_udr = 1'b1;
      step(3);
      vs_udr = 1'b0;
      step(3);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(2);
      checks++; if (cmd_bus.cmd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", cmd_bus.cmd_valid); end
      checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
      checks++; if (cmd_bus.cmd_data !== 38'h0 || cmd_bus.cmd_kind !== 1'b0 || cmd_bus.cmd_ir !== 2'b00 || cmd_bus.cmd_take_action !== 1'b0)
         begin failures++; $display("FAIL reset_outputs got data=%h kind=%b ir=%b ta=%b exp all 0", cmd_bus.cmd_data, cmd_bus.cmd_kind, cmd_bus.cmd_ir, cmd_bus.cmd_take_action); end
      reset = 1'b0;
      step(5);
   endtask

   task automatic test_single_dr();
      sr = 38'h20000000AB;
      ir_in = 2'b01;
      vs_udr = 1'b1;
      step();
      checks++; if (cmd_bus.cmd_valid !== 1'b0) begin failures++; $display("FAIL single_edge0_valid got=%b exp=0", cmd_bus.cmd_valid); end
      step();
      checks++; if (cmd_bus.cmd_valid !== 1'b0) begin failures++; $display("FAIL single_edge1_valid got=%b exp=0", cmd_bus.cmd_valid); end
      step();
      checks++; if (cmd_bus.cmd_valid !== 1'b1) begin failures++; $display("FAIL single_edge2_valid got=%b exp=1", cmd_bus.cmd_valid); end
      checks++; if (cmd_bus.cmd_kind !== CMD_DR || cmd_bus.cmd_ir !== 2'b01) begin failures++; $display("FAIL single_kind_ir got=%b/%b exp=0/01", cmd_bus.cmd_kind, cmd_bus.cmd_ir); end
      checks++; if (cmd_bus.cmd_data !== 38'h20000000AB) begin failures++; $display("FAIL single_data got=%h exp=20000000ab", cmd_bus.cmd_data); end
      checks++; if (cmd_bus.cmd_take_action !== 1'b1) begin failures++; $display("FAIL single_take_action got=%b exp=1", cmd_bus.cmd_take_action); end
      checks++; if (fifo_level !== 3'd1) begin failures++; $display("FAIL single_level got=%0d exp=1", fifo_level); end
      $display("pop kind=%b ir=%b data=%h", cmd_bus.cmd_kind, cmd_bus.cmd_ir, cmd_bus.cmd_data);
      step();
      vs_udr = 1'b0;
      cmd_bus.cmd_ready = 1'b1;
      step();
      cmd_bus.cmd_ready = 1'b0;
      checks++; if (fifo_level !== 3'd0 || cmd_bus.cmd_valid !== 1'b0) begin failures++; $display("FAIL single_pop got level=%0d valid=%b exp 0/0", fifo_level, cmd_bus.cmd_valid); end
      checks++; if (cmd_bus.cmd_data !== 38'h0) begin failures++; $display("FAIL single_empty_data got=%h exp=0", cmd_bus.cmd_data); end
      step(3);
   endtask

   task automatic test_burst();
      for (int i = 0; i < 6; i++) dr_event(38'h1000 + 38'(i), 2'(i));
      step(2);
      checks++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL burst_level got=%0d exp=4", fifo_level); end
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL burst_overflow got=%b exp=1", overflow); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (cmd_bus.cmd_valid !== 1'b1 || cmd_bus.cmd_kind !== CMD_DR || cmd_bus.cmd_data !== 38'h1000 + 38'(i) || cmd_bus.cmd_ir !== 2'(i)) begin
            failures++;
            $display("FAIL burst_entry%0d got valid=%b kind=%b ir=%b data=%h exp 1/0/%0d/%h", i, cmd_bus.cmd_valid, cmd_bus.cmd_kind, cmd_bus.cmd_ir, cmd_bus.cmd_data, i, 38'h1000 + 38'(i));
         end
         $display("pop kind=%b ir=%b data=%h", cmd_bus.cmd_kind, cmd_bus.cmd_ir, cmd_bus.cmd_data);
         cmd_bus.cmd_ready = 1'b1;
         step();
         cmd_bus.cmd_ready = 1'b0;
      end
      checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL burst_drained got=%0d exp=0", fifo_level); end
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL burst_sticky got=%b exp=1", overflow); end
      overflow_clr = 1'b1;
      step();
      overflow_clr = 1'b0;
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL burst_clear got=%b exp=0", overflow); end
   endtask

   task automatic test_simultaneous();
      sr = 38'h3FFFFF0001;
      ir_in = 2'b10;
      vs_udr = 1'b1;
      vs_uir = 1'b1;
      step(3);
      checks++; if (fifo_level !== 3'd1 || cmd_bus.cmd_kind !== CMD_IR) begin failures++; $display("FAIL simul_ir_first got level=%0d kind=%b exp 1/1", fifo_level, cmd_bus.cmd_kind); end
      checks++; if (cmd_bus.cmd_data !== 38'h0 || cmd_bus.cmd_take_action !== 1'b0 || cmd_bus.cmd_ir !== 2'b10)
         begin failures++; $display("FAIL simul_ir_fields got data=%h ta=%b ir=%b exp 0/0/10", cmd_bus.cmd_data, cmd_bus.cmd_take_action, cmd_bus.cmd_ir); end
      step();
      checks++; if (fifo_level !== 3'd2) begin failures++; $display("FAIL simul_pending_push got=%0d exp=2", fifo_level); end
      vs_udr = 1'b0;
      vs_uir = 1'b0;
      step(3);
      $display("pop kind=%b ir=%b data=%h", cmd_bus.cmd_kind, cmd_bus.cmd_ir, cmd_bus.cmd_data);
      cmd_bus.cmd_ready = 1'b1;
      step();
      cmd_bus.cmd_ready = 1'b0;
      checks++; if (cmd_bus.cmd_kind !== CMD_DR || cmd_bus.cmd_data !== 38'h3FFFFF0001 || cmd_bus.cmd_take_action !== 1'b1 || cmd_bus.cmd_ir !== 2'b10)
         begin failures++; $display("FAIL simul_dr_second got kind=%b data=%h ta=%b ir=%b exp 0/3fffff0001/1/10", cmd_bus.cmd_kind, cmd_bus.cmd_data, cmd_bus.cmd_take_action, cmd_bus.cmd_ir); end
      $display("pop kind=%b ir=%b data=%h", cmd_bus.cmd_kind, cmd_bus.cmd_ir, cmd_bus.cmd_data);
      cmd_bus.cmd_ready = 1'b1;
      step();
      cmd_bus.cmd_ready = 1'b0;
      checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL simul_drained got=%0d exp=0", fifo_level); end
   endtask

   task automatic test_full_pop_push();
      for (int i = 0; i < 4; i++) dr_event(38'h2000 + 38'(i), 2'(i));
      checks++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL fullpp_fill got=%0d exp=4", fifo_level); end
      sr = 38'h2004;
      ir_in = 2'b00;
      vs_udr = 1'b1;
      step(2);
      cmd_bus.cmd_ready = 1'b1;
      step();
      cmd_bus.cmd_ready = 1'b0;
      checks++; if (fifo_level !== 3'd4 || overflow !== 1'b0) begin failures++; $display("FAIL fullpp_same_cycle got level=%0d ovf=%b exp 4/0", fifo_level, overflow); end
      step();
      vs_udr = 1'b0;
      step(3);
      for (int i = 1; i < 5; i++) begin
         checks++;
         if (cmd_bus.cmd_data !== 38'h2000 + 38'(i)) begin failures++; $display("FAIL fullpp_entry%0d got=%h exp=%h", i, cmd_bus.cmd_data, 38'h2000 + 38'(i)); end
         $display("pop kind=%b ir=%b data=%h", cmd_bus.cmd_kind, cmd_bus.cmd_ir, cmd_bus.cmd_data);
         cmd_bus.cmd_ready = 1'b1;
         step();
         cmd_bus.cmd_ready = 1'b0;
      end
      checks++; if (fifo_level !== 3'd0 || overflow !== 1'b0) begin failures++; $display("FAIL fullpp_end got level=%0d ovf=%b exp 0/0", fifo_level, overflow); end
   endtask

   task automatic test_high_through_reset();
      vs_udr = 1'b1;
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      step(6);
      checks++; if (cmd_bus.cmd_valid !== 1'b0 || fifo_level !== 3'd0) begin failures++; $display("FAIL holdoff_no_event got valid=%b level=%0d exp 0/0", cmd_bus.cmd_valid, fifo_level); end
      vs_udr = 1'b0;
      step(4);
      sr = 38'h0ABC;
      ir_in = 2'b11;
      vs_udr = 1'b1;
      step(4);
      vs_udr = 1'b0;
      step(3);
      checks++; if (fifo_level !== 3'd1 || cmd_bus.cmd_data !== 38'h0ABC || cmd_bus.cmd_ir !== 2'b11)
         begin failures++; $display("FAIL holdoff_one_event got level=%0d data=%h ir=%b exp 1/abc/11", fifo_level, cmd_bus.cmd_data, cmd_bus.cmd_ir); end
      $display("pop kind=%b ir=%b data=%h", cmd_bus.cmd_kind, cmd_bus.cmd_ir, cmd_bus.cmd_data);
      cmd_bus.cmd_ready = 1'b1;
      step();
      cmd_bus.cmd_ready = 1'b0;
      checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL holdoff_drained got=%0d exp=0", fifo_level); end
   endtask

   task automatic test_reset_flush();
      for (int i = 0; i < 3; i++) dr_event(38'h3000 + 38'(i), 2'(i));
      checks++; if (fifo_level !== 3'd3) begin failures++; $display("FAIL flush_fill got=%0d exp=3", fifo_level); end
      #2;
      reset = 1'b1;
      #1;
      checks++; if (cmd_bus.cmd_valid !== 1'b0 || fifo_level !== 3'd0) begin failures++; $display("FAIL flush_immediate got valid=%b level=%0d exp 0/0", cmd_bus.cmd_valid, fifo_level); end
      checks++; if (cmd_bus.cmd_data !== 38'h0) begin failures++; $display("FAIL flush_data got=%h exp=0", cmd_bus.cmd_data); end
      step(2);
      reset = 1'b0;
      step(6);
      checks++; if (cmd_bus.cmd_valid !== 1'b0 || fifo_level !== 3'd0 || overflow !== 1'b0)
         begin failures++; $display("FAIL flush_after got valid=%b level=%0d ovf=%b exp 0/0/0", cmd_bus.cmd_valid, fifo_level, overflow); end
   endtask

   initial begin
      cmd_bus.cmd_ready = 1'b0;
      test_reset();
      test_single_dr();
      test_burst();
      test_simultaneous();
      test_full_pop_push();
      test_high_through_reset();
      test_reset_flush();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/nios2_debug_cmd_sync.md
# nios2_debug_cmd_sync

Parametrised system-clock side of the Nios II JTAG debug slave. Takes update-DR / update-IR strobes and the captured shift-register and IR contents from the TCK domain, resynchronises the strobes, and queues each update as a command in a small FIFO. The CPU debug logic pops commands through a valid/ready handshake. Successor to the fixed 38-bit, 2-bit-IR, unbuffered decode: adds configurable widths, buffering, overflow reporting and post-reset hold-off.

## Interface
Parameters:
- DATA_W, 38, width of shift register / command data
- IR_W, 2, width of virtual-JTAG IR
- SYNC_STAGES, 2, synchroniser flops on each strobe (>=2)
- FIFO_DEPTH, 4, command entries (power of two, >=2)

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  asynchronous, active-high reset
- vs_udr  in  1  update-DR level from TCK domain, asynchronous to clk
- vs_uir  in  1  update-IR level from TCK domain, asynchronous to clk
- ir_in  in  IR_W  current virtual IR, quasi-static
- sr  in  DATA_W  captured shift register, quasi-static
- cmd_valid  out  1  FIFO head valid
- cmd_ready  in  1  consumer accepts head
- cmd_kind  out  1  0 = DR update, 1 = IR update
- cmd_ir  out  IR_W  IR value captured with the entry
- cmd_data  out  DATA_W  sr captured with the entry; all zeros for IR entries
- cmd_take_action  out  1  cmd_data[DATA_W-1] for DR entries, 0 for IR entries
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries
- overflow  out  1  sticky flag: an event was dropped
- overflow_clr  in  1  clears overflow

## Operation
- Each strobe passes through a SYNC_STAGES flop chain, followed by a prev register. An event is syncN & ~prev (rising edge only). Falling edges are ignored.
- On a DR event, push {kind=0, ir_in, sr}. On an IR event, push {kind=1, ir_in, 0}. ir_in and sr are sampled on the push edge. The TCK side guarantees both are stable for >= SYNC_STAGES+2 clk cycles after the strobe rises.
- Simultaneous DR and IR events in one cycle: the IR entry is pushed first. The DR entry is held in a one-entry pending slot and pushed the next cycle. Further events that arrive while the slot is occupied push normally after it.
- The FIFO is first-word-fall-through. A pop occurs when cmd_valid & cmd_ready.
- Full, no pop, push requested: the entry is dropped, overflow is set, and FIFO contents are unchanged.
- Full with pop and push in the same cycle: both occur and level is unchanged.
- Empty with push: the entry is visible on the outputs the next cycle. There is no same-cycle bypass.
- overflow_clr clears overflow. If a drop happens in the same cycle as overflow_clr, set wins.
- Hold-off: after reset deasserts, events are suppressed for SYNC_STAGES+1 cycles. During hold-off prev still tracks syncN, so a strobe already high at reset release produces no event.

## Timing
- Reset values: all sync and prev flops 0, hold-off counter loaded, pending slot empty, cmd_valid 0, fifo_level 0, overflow 0. cmd_kind, cmd_ir, cmd_data and cmd_take_action are 0 while the FIFO is empty.
- Latency: call the first clk edge that samples vs_udr high edge 0. The push occurs at edge SYNC_STAGES, and cmd_valid is high from edge SYNC_STAGES. With defaults this is 2 edges.
- Pending-slot DR entries are pushed one edge later than the IR entry.
- A strobe must stay high for >= SYNC_STAGES+1 clk cycles and low for the same between events; shorter pulses may be lost.
- Reset asserted mid-operation flushes the FIFO, the pending slot and overflow immediately (asynchronous).
- Outputs are registered or driven from FIFO storage; no combinational path from cmd_ready to cmd_valid.

## Structure
- Package nios2_debug_pkg holds:
  - the cmd_kind constants CMD_DR = 1'b0 and CMD_IR = 1'b1
  - the default widths DBG_DATA_W = 38 and DBG_IR_W = 2
- Sub-module nios2_debug_cmd_fifo implements the FWFT FIFO:
  - parametrised on entry width and depth
  - exposes push, pop, full, empty and level
  - the top level handles sync, edge detect, hold-off, pending slot and overflow.

## Test plan
- Single DR event: sr=38'h2_0000_00AB, ir_in=2'b01, vs_udr pulsed 4 cycles -> cmd_valid high 2 edges after first sample; kind 0, ir 01, data 2_0000_00AB, take_action 1; pop -> level 0.
- Burst: 6 DR events spaced 6 cycles, cmd_ready=0, depth 4 -> level 4, overflow=1, entries 1-4 intact in order; overflow_clr -> overflow 0.
- Simultaneous vs_udr and vs_uir rise -> IR entry (data 0) then DR entry one edge later; order IR, DR.
- Full FIFO with cmd_ready=1 and new event in the same cycle -> no drop, level stays 4, overflow stays 0.
- vs_udr held high through reset release -> no event; then low 4 cycles and high again -> exactly one event.
- Reset asserted with 3 queued entries -> cmd_valid 0 and level 0 immediately, no entries after release.
